// File: rtl/conv_pkg.sv
// Shared conv definitions: geometry defaults, collector FSM encoding and output-map sizing.
// Pure declarations; no logic of its own.
package conv_pkg;

   localparam int N_DUM    = 3;
   localparam int M        = 2;
   localparam int DATA_W   = 16;
   localparam int MAX_OUT  = 4;
   localparam int STRIDE_W = 3;
   localparam int OD_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CFG     = 3'd1,
      ST_COLLECT = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Returns 0 for configurations that yield no valid window (stride 0 or padded map smaller than filter).
   function automatic logic [OD_W-1:0] out_dim_f(
      input logic [STRIDE_W-1:0] stride,
      input logic [STRIDE_W-1:0] pad,
      input int                  n_dum = N_DUM,
      input int                  m     = M
   );
      int span;
      span = n_dum + 2 * int'(pad) - m;
      if (stride == '0 || span < 0) begin
         return '0;
      end
      return OD_W'(span / int'(stride) + 1);
   endfunction

endpackage

// File: rtl/conv_result_ram.sv
// Output-map buffer: simple dual-port, synchronous write, registered read (1-cycle latency).
// Read register only updates when rd_en_i is high, so a stalled reader keeps its word.
module conv_result_ram #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 16,
   parameter int AW     = 4
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_dat_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_dat_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
      if (rd_en_i) begin
         rd_dat_o <= mem_q[rd_addr_i];
      end
   end

endmodule

// File: rtl/conv_result_collector.sv
// Captures conv window sums into an output-map buffer, then streams the map row-major on m_*.
// First word valid 2 cycles after the final capture; m_data/m_last hold while m_valid & ~m_ready.
module conv_result_collector
   import conv_pkg::*;
#(
   parameter int N_DUM   = conv_pkg::N_DUM,
   parameter int M       = conv_pkg::M,
   parameter int DATA_W  = conv_pkg::DATA_W,
   parameter int MAX_OUT = conv_pkg::MAX_OUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [STRIDE_W-1:0] stride,
   input  logic [STRIDE_W-1:0] pad,
   input  logic [DATA_W-1:0]   conv_out,
   input  logic                conv_done,
   output logic [DATA_W-1:0]   m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                busy,
   output logic                frame_done,
   output logic                err_cfg
);

   localparam int DEPTH = MAX_OUT * MAX_OUT;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_e              state_q, state_d;
   logic [STRIDE_W-1:0] stride_q, stride_d;
   logic [STRIDE_W-1:0] pad_q, pad_d;
   logic [CNT_W-1:0]    total_q, total_d;
   logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]    rd_iss_q, rd_iss_d;
   logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic                s1_vld_q, s1_vld_d;
   logic                m_valid_q, m_valid_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;
   logic                err_q, err_d;
   logic                done_q;

   logic [OD_W-1:0]     od;
   logic                cfg_bad;
   logic                done_rise;
   logic                start_ok;
   logic                capture;
   logic                last_cap;
   logic                load;
   logic                accept;
   logic                issue;
   logic                last_acc;
   logic [DATA_W-1:0]   ram_rd_dat;

   assign od        = out_dim_f(stride_q, pad_q, N_DUM, M);
   assign cfg_bad   = (od == '0) || (od > OD_W'(MAX_OUT));
   assign done_rise = conv_done & ~done_q;
   assign start_ok  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign capture   = (state_q == ST_COLLECT) & done_rise;
   assign last_cap  = capture & (wr_cnt_q == total_q - CNT_W'(1));

   // Two-stage read pipe: RAM read register (s1) feeding the output register; both freeze on a stall.
   assign load      = ~m_valid_q | m_ready;
   assign accept    = m_valid_q & m_ready;
   assign issue     = (state_q == ST_DRAIN) & (rd_iss_q < total_q) & (~s1_vld_q | load);
   assign last_acc  = accept & (rd_cnt_q == total_q - CNT_W'(1));

   conv_result_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clk_i     (clk),
      .wr_en_i   (capture),
      .wr_addr_i (wr_cnt_q[AW-1:0]),
      .wr_dat_i  (conv_out),
      .rd_en_i   (issue),
      .rd_addr_i (rd_iss_q[AW-1:0]),
      .rd_dat_o  (ram_rd_dat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_CFG;
         ST_CFG:     state_d = cfg_bad ? ST_IDLE : ST_COLLECT;
         ST_COLLECT: if (last_cap) state_d = ST_DRAIN;
         ST_DRAIN:   if (last_acc) state_d = ST_DONE;
         ST_DONE:    state_d = start ? ST_CFG : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         ST_CFG, ST_COLLECT, ST_DRAIN: busy = 1'b1;
         ST_DONE:                      frame_done = 1'b1;
         default:                      ;
      endcase
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_valid_q & (rd_cnt_q == total_q - CNT_W'(1));
   assign err_cfg = err_q;

   always_comb begin
      stride_d  = stride_q;
      pad_d     = pad_q;
      total_d   = total_q;
      wr_cnt_d  = wr_cnt_q;
      rd_iss_d  = rd_iss_q;
      rd_cnt_d  = rd_cnt_q;
      s1_vld_d  = s1_vld_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      err_d     = err_q;

      if (start_ok) begin
         stride_d = stride;
         pad_d    = pad;
         err_d    = 1'b0;
      end

      if (state_q == ST_CFG) begin
         if (cfg_bad) begin
            err_d = 1'b1;
         end else begin
            total_d = CNT_W'(od * od);
         end
         wr_cnt_d = '0;
         rd_iss_d = '0;
         rd_cnt_d = '0;
      end

      if (capture) begin
         wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end

      if (state_q == ST_DRAIN) begin
         // A fresh done edge here means conv produced more windows than the map holds.
         if (done_rise) begin
            err_d = 1'b1;
         end
         if (load) begin
            m_valid_d = s1_vld_q;
            if (s1_vld_q) begin
               m_data_d = ram_rd_dat;
            end
         end
         if (issue) begin
            rd_iss_d = rd_iss_q + CNT_W'(1);
            s1_vld_d = 1'b1;
         end else if (load) begin
            s1_vld_d = 1'b0;
         end
         if (accept) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
         end
      end else begin
         m_valid_d = 1'b0;
         s1_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stride_q  <= '0;
         pad_q     <= '0;
         total_q   <= '0;
         wr_cnt_q  <= '0;
         rd_iss_q  <= '0;
         rd_cnt_q  <= '0;
         s1_vld_q  <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         stride_q  <= stride_d;
         pad_q     <= pad_d;
         total_q   <= total_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_iss_q  <= rd_iss_d;
         rd_cnt_q  <= rd_cnt_d;
         s1_vld_q  <= s1_vld_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         err_q     <= err_d;
         done_q    <= conv_done;
      end
   end

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: table of frames plus hand sequences for
// bad config, overflow and mid-drain reset. Inputs driven and outputs sampled on negedge.
module tb_conv_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  stride;
   logic [2:0]  pad;
   logic [15:0] conv_out;
   logic        conv_done;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic        frame_done;
   logic        err_cfg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv_result_collector dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stride     (stride),
      .pad        (pad),
      .conv_out   (conv_out),
      .conv_done  (conv_done),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .busy       (busy),
      .frame_done (frame_done),
      .err_cfg    (err_cfg)
   );

   typedef struct {
      logic [2:0]        stride;
      logic [2:0]        pad;
      int                n;
      logic [15:0][15:0] dat;
      logic [3:0]        rdy_pat;
      int                done_len;
   } vec_t;

   vec_t vecs [4];

   task automatic chk_b(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   task automatic chk_d(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic start_frame(input logic [2:0] s, input logic [2:0] p, input int id);
      stride = s;
      pad    = p;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_b($sformatf("f%0d busy_cfg", id), busy, 1'b1);
      chk_b($sformatf("f%0d err_cleared", id), err_cfg, 1'b0);
      @(negedge clk);
      chk_b($sformatf("f%0d busy_collect", id), busy, 1'b1);
      chk_b($sformatf("f%0d err_collect", id), err_cfg, 1'b0);
   endtask

   // Leaves the bench at the negedge where the first word should just have become valid.
   task automatic collect(input vec_t v, input int id);
      for (int i = 0; i < v.n; i++) begin
         conv_out  = v.dat[i];
         conv_done = 1'b1;
         for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            if (h + 1 >= v.done_len) conv_done = 1'b0;
            if (i == v.n - 1)
               chk_b($sformatf("f%0d valid_latency_c%0d", id, h + 1), m_valid, h == 2);
            else if (h + 1 >= v.done_len)
               break;
         end
         if (i != v.n - 1) @(negedge clk);
      end
   endtask

   task automatic drain(input vec_t v, input int id);
      int          got = 0;
      int          k = 0;
      logic        hold_pend = 1'b0;
      logic [15:0] held = '0;
      logic        held_last = 1'b0;
      while (got < v.n && k < 200) begin
         if (hold_pend) begin
            chk_d($sformatf("f%0d hold_data", id), m_data, held);
            chk_b($sformatf("f%0d hold_last", id), m_last, held_last);
            chk_b($sformatf("f%0d hold_valid", id), m_valid, 1'b1);
            hold_pend = 1'b0;
         end
         m_ready = v.rdy_pat[k % 4];
         if (m_valid && m_ready) begin
            chk_d($sformatf("f%0d word%0d", id, got), m_data, v.dat[got]);
            chk_b($sformatf("f%0d last%0d", id, got), m_last, got == v.n - 1);
            got++;
         end else if (m_valid) begin
            held      = m_data;
            held_last = m_last;
            hold_pend = 1'b1;
         end
         @(negedge clk);
         k++;
      end
      m_ready = 1'b0;
      chk_i($sformatf("f%0d word_count", id), got, v.n);
      chk_b($sformatf("f%0d frame_done", id), frame_done, 1'b1);
      chk_b($sformatf("f%0d valid_done", id), m_valid, 1'b0);
      @(negedge clk);
      chk_b($sformatf("f%0d frame_done_pulse", id), frame_done, 1'b0);
      chk_b($sformatf("f%0d busy_after", id), busy, 1'b0);
      chk_b($sformatf("f%0d err_after", id), err_cfg, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stride    = '0;
      pad       = '0;
      conv_out  = '0;
      conv_done = 1'b0;
      m_ready   = 1'b0;

      vecs[0].stride = 3'd1; vecs[0].pad = 3'd0; vecs[0].n = 4;
      vecs[0].rdy_pat = 4'b1111; vecs[0].done_len = 1; vecs[0].dat = '0;
      vecs[0].dat[0] = 16'h0005; vecs[0].dat[1] = 16'hFFFE;
      vecs[0].dat[2] = 16'h0010; vecs[0].dat[3] = 16'h0000;

      vecs[1].stride = 3'd1; vecs[1].pad = 3'd1; vecs[1].n = 16;
      vecs[1].rdy_pat = 4'b1111; vecs[1].done_len = 1; vecs[1].dat = '0;
      for (int i = 0; i < 16; i++) vecs[1].dat[i] = 16'(i + 1);

      vecs[2].stride = 3'd2; vecs[2].pad = 3'd0; vecs[2].n = 1;
      vecs[2].rdy_pat = 4'b1111; vecs[2].done_len = 1; vecs[2].dat = '0;
      vecs[2].dat[0] = 16'h8000;

      vecs[3].stride = 3'd1; vecs[3].pad = 3'd0; vecs[3].n = 4;
      vecs[3].rdy_pat = 4'b1001; vecs[3].done_len = 3; vecs[3].dat = '0;
      vecs[3].dat[0] = 16'h1234; vecs[3].dat[1] = 16'hABCD;
      vecs[3].dat[2] = 16'h00FF; vecs[3].dat[3] = 16'h7FFF;

      repeat (3) @(negedge clk);
      chk_b("reset m_valid", m_valid, 1'b0);
      chk_b("reset m_last", m_last, 1'b0);
      chk_b("reset busy", busy, 1'b0);
      chk_b("reset frame_done", frame_done, 1'b0);
      chk_b("reset err_cfg", err_cfg, 1'b0);
      chk_d("reset m_data", m_data, 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         start_frame(vecs[i].stride, vecs[i].pad, i);
         collect(vecs[i], i);
         drain(vecs[i], i);
      end

      // Bad configurations, then a good one clears the sticky error.
      stride = 3'd0; pad = 3'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_b("stride0 busy_cfg", busy, 1'b1);
      @(negedge clk);
      chk_b("stride0 err", err_cfg, 1'b1);
      chk_b("stride0 busy", busy, 1'b0);
      stride = 3'd1; pad = 3'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_b("pad3 err_cleared", err_cfg, 1'b0);
      @(negedge clk);
      chk_b("pad3 err", err_cfg, 1'b1);
      chk_b("pad3 busy", busy, 1'b0);
      start_frame(3'd1, 3'd0, 10);
      collect(vecs[0], 10);
      drain(vecs[0], 10);

      // Extra done edge during drain flags overflow and leaves the output word alone.
      start_frame(3'd2, 3'd0, 20);
      collect(vecs[2], 20);
      m_ready   = 1'b0;
      conv_done = 1'b1;
      @(negedge clk);
      conv_done = 1'b0;
      chk_b("ovf err", err_cfg, 1'b1);
      chk_b("ovf valid", m_valid, 1'b1);
      chk_d("ovf data", m_data, 16'h8000);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk_b("ovf frame_done", frame_done, 1'b1);
      @(negedge clk);
      chk_b("ovf err_sticky", err_cfg, 1'b1);

      // Reset after two accepted words aborts the frame; a fresh frame then runs normally.
      start_frame(3'd1, 3'd0, 30);
      collect(vecs[0], 30);
      m_ready = 1'b1;
      chk_d("rst word0", m_data, 16'h0005);
      @(negedge clk);
      chk_d("rst word1", m_data, 16'hFFFE);
      @(negedge clk);
      m_ready = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_b("rst m_valid", m_valid, 1'b0);
      chk_b("rst busy", busy, 1'b0);
      chk_b("rst m_last", m_last, 1'b0);
      chk_b("rst err", err_cfg, 1'b0);
      start_frame(3'd1, 3'd1, 31);
      collect(vecs[1], 31);
      drain(vecs[1], 31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
